// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains uart_rx bytes into a DEPTH-entry circular FIFO
// with level, flags, sticky overflow and a threshold interrupt.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int THRESH = 6,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_read,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  input  logic          clear,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          thresh_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          acc;

  assign empty      = (level == '0);
  assign full       = (level == LW'(DEPTH));
  assign thresh_irq = (level >= LW'(THRESH));
  assign rd_data    = empty ? 8'hFF : mem[rd_ptr];

  // rx_read high means the byte on rx_data was already taken
  assign push = rx_valid & ~rx_read;
  assign pop  = rd_en & ~empty;
  // a same-cycle pop frees the slot a full FIFO needs
  assign acc  = push & (~full | pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rx_read  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_read <= push;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
      end else begin
        if (acc)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push && !acc)
          overflow <= 1'b1;
        if (acc && !pop)
          level <= level + 1'b1;
        else if (pop && !acc)
          level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc && !clear)
      mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, directed corner sequences and a
// random run against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 8;
  localparam int THRESH = 6;
  localparam int LW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_read;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          clear;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          thresh_irq;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_read(rx_read),
    .rd_en(rd_en), .rd_data(rd_data), .clear(clear),
    .level(level), .empty(empty), .full(full),
    .overflow(overflow), .thresh_irq(thresh_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference: byte queue, sticky drop flag, last-cycle ack
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_ack;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       c;
    int         lvl;
    logic [7:0] data;
    logic       ovf;
    logic       ack;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input bit r, input bit c,
                            input logic [7:0] d);
    bit take;
    take = v && !m_ack;
    if (c) begin
      q.delete();
      m_ovf = 0;
    end else begin
      if (r && q.size() > 0)
        void'(q.pop_front());
      if (take) begin
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1;
      end
    end
    m_ack = take;
  endtask

  task automatic chk_model();
    chk("level", int'(level), q.size());
    chk("rd_data", int'(rd_data), q.size() > 0 ? int'(q[0]) : 'hFF);
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("thresh_irq", int'(thresh_irq), int'(q.size() >= THRESH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("rx_read", int'(rx_read), int'(m_ack));
  endtask

  // one clock: drive, advance model and DUT, sample 1 time unit after edge
  task automatic cyc(input bit v, input logic [7:0] d, input bit r,
                     input bit c, input bit do_chk);
    rx_valid = v; rx_data = d; rd_en = r; clear = c;
    model_step(v, r, c, d);
    @(posedge clk);
    #1;
    rx_valid = 0; rd_en = 0; clear = 0;
    if (do_chk) chk_model();
  endtask

  task automatic push_gap(input logic [7:0] d);
    cyc(1, d, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [7:0] last;
    rstn = 0; rx_valid = 0; rx_data = 0; rd_en = 0; clear = 0;
    q.delete(); m_ovf = 0; m_ack = 0;
    #12;
    chk("rst level", int'(level), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst thresh", int'(thresh_irq), 0);
    chk("rst rd_data", int'(rd_data), 'hFF);
    chk("rst overflow", int'(overflow), 0);
    chk("rst rx_read", int'(rx_read), 0);
    rstn = 1;
    @(posedge clk); #1;

    vecs[0]  = '{1, 8'h41, 0, 0, 1, 8'h41, 0, 1};
    vecs[1]  = '{1, 8'h41, 0, 0, 1, 8'h41, 0, 0};
    vecs[2]  = '{0, 8'h00, 0, 0, 1, 8'h41, 0, 0};
    vecs[3]  = '{1, 8'h42, 0, 0, 2, 8'h41, 0, 1};
    vecs[4]  = '{0, 8'h00, 1, 0, 1, 8'h42, 0, 0};
    vecs[5]  = '{1, 8'h43, 1, 0, 1, 8'h43, 0, 1};
    vecs[6]  = '{0, 8'h00, 1, 0, 0, 8'hFF, 0, 0};
    vecs[7]  = '{0, 8'h00, 1, 0, 0, 8'hFF, 0, 0};
    vecs[8]  = '{1, 8'h55, 0, 1, 0, 8'hFF, 0, 1};
    vecs[9]  = '{1, 8'h55, 0, 0, 0, 8'hFF, 0, 0};
    vecs[10] = '{1, 8'h55, 0, 0, 1, 8'h55, 0, 1};
    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c, 0);
      chk($sformatf("vec%0d level", i), int'(level), vecs[i].lvl);
      chk($sformatf("vec%0d rd_data", i), int'(rd_data), int'(vecs[i].data));
      chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].ovf));
      chk($sformatf("vec%0d rx_read", i), int'(rx_read), int'(vecs[i].ack));
    end
    cyc(0, 0, 0, 1, 1);

    // fill past full: ninth byte acknowledged but dropped
    for (int i = 0; i < 9; i++) begin
      cyc(1, 8'(i), 0, 0, 1);
      if (i == 7) chk("full after 8", int'(full), 1);
      if (i == 8) begin
        chk("9th acked", int'(rx_read), 1);
        chk("9th level", int'(level), 8);
        chk("9th overflow", int'(overflow), 1);
      end
      cyc(0, 0, 0, 0, 1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("drain head", int'(rd_data), i);
      cyc(0, 0, 1, 0, 1);
    end
    chk("drained empty", int'(empty), 1);
    chk("ovf sticky", int'(overflow), 1);
    cyc(1, 8'hAA, 0, 1, 1);
    chk("clr level", int'(level), 0);
    chk("clr overflow", int'(overflow), 0);
    chk("clr rx_read", int'(rx_read), 1);
    cyc(0, 0, 0, 0, 1);

    // push and pop together while full
    for (int i = 0; i < 8; i++) push_gap(8'h10 + 8'(i));
    cyc(1, 8'h99, 1, 0, 1);
    chk("full pp level", int'(level), 8);
    chk("full pp ovf", int'(overflow), 0);
    last = 0;
    for (int i = 0; i < 8; i++) begin
      last = rd_data;
      cyc(0, 0, 1, 0, 1);
    end
    chk("last byte", int'(last), 'h99);

    // push and pop together at level 1
    push_gap(8'h21);
    cyc(1, 8'h22, 1, 0, 1);
    chk("l1 pp level", int'(level), 1);
    chk("l1 pp head", int'(rd_data), 'h22);
    cyc(0, 0, 1, 0, 1);

    // threshold crossing
    for (int i = 0; i < 5; i++) push_gap(8'h30 + 8'(i));
    chk("irq at 5", int'(thresh_irq), 0);
    cyc(1, 8'h35, 0, 0, 1);
    chk("irq at 6", int'(thresh_irq), 1);
    cyc(0, 0, 1, 0, 1);
    chk("irq after pop", int'(thresh_irq), 0);
    cyc(0, 0, 0, 1, 1);

    // async reset between edges with rx_read high
    for (int i = 0; i < 3; i++) push_gap(8'h60 + 8'(i));
    cyc(1, 8'h63, 0, 0, 1);
    chk("pre-rst level", int'(level), 4);
    chk("pre-rst rx_read", int'(rx_read), 1);
    #2 rstn = 0;
    #1;
    chk("async level", int'(level), 0);
    chk("async empty", int'(empty), 1);
    chk("async rx_read", int'(rx_read), 0);
    q.delete(); m_ovf = 0; m_ack = 0;
    @(negedge clk);
    rstn = 1;
    @(posedge clk); #1;
    cyc(0, 0, 1, 0, 1);
    chk("empty pop level", int'(level), 0);
    chk("empty pop rd", int'(rd_data), 'hFF);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 1) == 1), 8'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
